// File: rtl/float_add_issue.sv
// Issue controller in front of the single-precision adder: resolves IEEE-754 special
// operands locally, issues ordinary pairs to the adder and guards the wait with a timeout.
module float_add_issue #(
    parameter int TIMEOUT = 64
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        InValid,
    output logic        InReady,
    input  logic [31:0] InOp1,
    input  logic [31:0] InOp2,
    output logic [31:0] AddOp1,
    output logic [31:0] AddOp2,
    output logic        AddInputValid,
    input  logic [31:0] AddResult,
    input  logic        AddResultValid,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] OutResult,
    output logic        OutBypass,
    output logic        TimeoutErr
);

    localparam logic [31:0] QNAN         = 32'h7FC0_0000;
    localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    state_t      state;
    logic [7:0]  wait_cnt;

    logic        s1, s2;
    logic [7:0]  e1, e2;
    logic [22:0] m1, m2;
    logic        nan1, nan2, inf1, inf2, zero1, zero2;
    logic        bypass;
    logic [31:0] bypass_res;

    assign {s1, e1, m1} = InOp1;
    assign {s2, e2, m2} = InOp2;

    // A zero exponent covers both true zeros and denormals, which flush to signed zero.
    assign nan1  = (e1 == 8'hFF) && (m1 != 23'd0);
    assign nan2  = (e2 == 8'hFF) && (m2 != 23'd0);
    assign inf1  = (e1 == 8'hFF) && (m1 == 23'd0);
    assign inf2  = (e2 == 8'hFF) && (m2 == 23'd0);
    assign zero1 = (e1 == 8'h00);
    assign zero2 = (e2 == 8'h00);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        bypass     = 1'b1;
        bypass_res = '0;
        if (nan1 || nan2)                   bypass_res = QNAN;
        else if (inf1 && inf2 && (s1 != s2)) bypass_res = QNAN;
        else if (inf1)                      bypass_res = InOp1;
        else if (inf2)                      bypass_res = InOp2;
        else if (zero1 && zero2)            bypass_res = {s1 & s2, 31'd0};
        else if (zero1)                     bypass_res = InOp2;
        else if (zero2)                     bypass_res = InOp1;
        else                                bypass     = 1'b0;
    end

    always_ff @(posedge Clock) begin
        // NOTE: the operand/result registers are plain flops, so resetting them is cheap and
        // gives the documented all-zero reset state.
        if (Reset) begin
            state      <= IDLE;
            wait_cnt   <= 8'd0;
            AddOp1     <= '0;
            AddOp2     <= '0;
            OutResult  <= '0;
            OutBypass  <= 1'b0;
            TimeoutErr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (InValid) begin
                        if (bypass) begin
                            OutResult <= bypass_res;
                            OutBypass <= 1'b1;
                            state     <= OUT;
                        end else begin
                            AddOp1 <= InOp1;
                            AddOp2 <= InOp2;
                            state  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt <= 8'd0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
                    // The first WAIT cycle still sees the previous operation's valid level.
                    if (AddResultValid && (wait_cnt != 8'd0)) begin
                        OutResult <= AddResult;
                        OutBypass <= 1'b0;
                        state     <= OUT;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        OutResult  <= QNAN;
                        OutBypass  <= 1'b0;
                        TimeoutErr <= 1'b1;
                        state      <= OUT;
                    end
                end
                OUT: begin
                    if (OutReady) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign InReady       = (state == IDLE);
    assign AddInputValid = (state == ISSUE);
    assign OutValid      = (state == OUT);

endmodule

// File: tb/tb_float_add_issue.sv
// Randomized bench for float_add_issue: a behavioural adder stand-in plus a rule-level
// reference for the special-value bypass and the expected handshake latencies.
module tb_float_add_issue;

    localparam int TO = 8;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [31:0] InOp1 = '0, InOp2 = '0;
    logic [31:0] AddOp1, AddOp2;
    logic        AddInputValid;
    logic [31:0] AddResult = '0;
    logic        AddResultValid = 1'b0;
    logic        OutValid;
    logic        OutReady = 1'b1;
    logic [31:0] OutResult;
    logic        OutBypass;
    logic        TimeoutErr;

    float_add_issue #(.TIMEOUT(TO)) dut (
        .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .InOp1(InOp1), .InOp2(InOp2), .AddOp1(AddOp1), .AddOp2(AddOp2),
        .AddInputValid(AddInputValid), .AddResult(AddResult), .AddResultValid(AddResultValid),
        .OutValid(OutValid), .OutReady(OutReady), .OutResult(OutResult),
        .OutBypass(OutBypass), .TimeoutErr(TimeoutErr)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Adder stand-in: answers adder_lat cycles after the issue pulse, level held until next issue.
    int          adder_lat    = 4;
    bit          adder_silent = 1'b0;
    bit          hold_stale   = 1'b0;
    logic [31:0] adder_value  = '0;
    int          left         = 0;
    bit          busy         = 1'b0;
    int          pulse_cnt    = 0;
    logic [31:0] cap_op1 = '0, cap_op2 = '0;

    always @(posedge Clock) begin
        if (Reset) begin
            AddResultValid <= 1'b0;
            busy           <= 1'b0;
        end else if (AddInputValid) begin
            pulse_cnt <= pulse_cnt + 1;
            cap_op1   <= AddOp1;
            cap_op2   <= AddOp2;
            busy      <= 1'b1;
            left      <= adder_lat - 1;
            if (!hold_stale) AddResultValid <= 1'b0;
        end else if (busy && !adder_silent) begin
            if (left == 0) begin
                AddResultValid <= 1'b1;
                AddResult      <= adder_value;
                busy           <= 1'b0;
            end else begin
                left <= left - 1;
            end
        end
    end

    // Reference for the special-value rules: returns {bypass, result}.
    function automatic logic [32:0] ref_model(input logic [31:0] a, input logic [31:0] b);
        bit nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        nan_a  = (a[30:23] == 8'd255) && (a[22:0] != 0);
        nan_b  = (b[30:23] == 8'd255) && (b[22:0] != 0);
        inf_a  = (a[30:23] == 8'd255) && (a[22:0] == 0);
        inf_b  = (b[30:23] == 8'd255) && (b[22:0] == 0);
        zero_a = (a[30:23] == 8'd0);
        zero_b = (b[30:23] == 8'd0);
        if (nan_a || nan_b)                    return {1'b1, 32'h7FC00000};
        if (inf_a && inf_b && (a[31] != b[31])) return {1'b1, 32'h7FC00000};
        if (inf_a)                             return {1'b1, a};
        if (inf_b)                             return {1'b1, b};
        if (zero_a && zero_b)                  return {1'b1, a[31] & b[31], 31'd0};
        if (zero_a)                            return {1'b1, b};
        if (zero_b)                            return {1'b1, a};
        return {1'b0, 32'd0};
    endfunction

    logic        exp_terr = 1'b0;
    logic [31:0] last_level_value = '0;

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int lat,
                         input bit silent, input bit stale, input int stall,
                         input logic [31:0] aval);
        logic [32:0] m;
        logic [31:0] exp_res;
        int          exp_lat, exp_p, p0, c;
        bit          timed_out;
        m         = ref_model(a, b);
        timed_out = 1'b0;
        if (m[32]) begin
            exp_lat = 1; exp_res = m[31:0]; exp_p = 0;
        end else if (stale) begin
            exp_lat = 4; exp_res = last_level_value; exp_p = 1;
        end else if (silent) begin
            exp_lat = TO + 2; exp_res = 32'h7FC00000; exp_p = 1; timed_out = 1'b1;
            exp_terr = 1'b1;
        end else begin
            exp_lat = lat + 3; exp_res = aval; exp_p = 1;
            last_level_value = aval;
        end
        @(negedge Clock);
        adder_lat    = lat;
        adder_silent = silent || stale;
        hold_stale   = stale;
        adder_value  = aval;
        OutReady     = (stall == 0);
        p0           = pulse_cnt;
        InValid      = 1'b1;
        InOp1        = a;
        InOp2        = b;
        c = 0;
        while (!InReady && c < 50) begin
            @(negedge Clock);
            c++;
        end
        check("in_ready", 32'(InReady), 32'd1);
        @(posedge Clock);
        @(negedge Clock);
        InValid = 1'b0;
        c = 1;
        while (!OutValid && c < 300) begin
            @(negedge Clock);
            c++;
        end
        check("latency", 32'(c), 32'(exp_lat));
        check("result", OutResult, exp_res);
        if (!timed_out) check("bypass", 32'(OutBypass), 32'(m[32]));
        check("issue_pulses", 32'(pulse_cnt - p0), 32'(exp_p));
        if (exp_p == 1) begin
            check("add_op1", cap_op1, a);
            check("add_op2", cap_op2, b);
        end
        check("timeout_err", 32'(TimeoutErr), 32'(exp_terr));
        for (int i = 0; i < stall; i++) begin
            @(negedge Clock);
            check("hold_valid", 32'(OutValid), 32'd1);
            check("hold_result", OutResult, exp_res);
            check("hold_in_ready", 32'(InReady), 32'd0);
        end
        OutReady = 1'b1;
        @(negedge Clock);
        check("out_drop", 32'(OutValid), 32'd0);
        check("ready_back", 32'(InReady), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset    = 1'b0;
        exp_terr = 1'b0;
    endtask

    function automatic logic [31:0] rand_operand();
        logic [7:0]  e;
        logic [22:0] mt;
        mt = 23'($urandom);
        case ($urandom_range(0, 5))
            0: begin e = 8'd0;   mt = 23'd0; end
            1: begin e = 8'd0;   mt = mt | 23'd1; end
            2: begin e = 8'd255; mt = 23'd0; end
            3: begin e = 8'd255; mt = mt | 23'd1; end
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {1'($urandom), e, mt};
    endfunction

    initial begin
        int quiet;
        repeat (3) @(negedge Clock);
        check("rst_in_ready", 32'(InReady), 32'd1);
        check("rst_issue", 32'(AddInputValid), 32'd0);
        check("rst_out_valid", 32'(OutValid), 32'd0);
        check("rst_bypass", 32'(OutBypass), 32'd0);
        check("rst_timeout_err", 32'(TimeoutErr), 32'd0);
        check("rst_add_op1", AddOp1, 32'd0);
        check("rst_add_op2", AddOp2, 32'd0);
        check("rst_result", OutResult, 32'd0);
        Reset = 1'b0;

        // Directed cases
        do_op(32'h3F800000, 32'h40000000, 4, 0, 0, 0, 32'h40400000);
        do_op(32'h3F800000, 32'h40000000, 4, 0, 1, 0, 32'h11111111);
        do_op(32'h7F800001, 32'h3F800000, 4, 0, 0, 0, 32'h0);
        do_op(32'h7F800000, 32'hFF800000, 4, 0, 0, 0, 32'h0);
        do_op(32'hFF800000, 32'h40000000, 4, 0, 0, 0, 32'h0);
        do_op(32'h80000000, 32'h80000000, 4, 0, 0, 0, 32'h0);
        do_op(32'h00000000, 32'h80000000, 4, 0, 0, 0, 32'h0);
        do_op(32'h00000001, 32'hC0A00000, 4, 0, 0, 0, 32'h0);
        do_op(32'h3F800000, 32'h3F800000, 1, 0, 0, 0, 32'h40000000);
        do_op(32'h40400000, 32'h3F800000, TO - 1, 0, 0, 0, 32'h40800000);
        check("simultaneous_no_err", 32'(TimeoutErr), 32'd0);
        do_op(32'h41200000, 32'h41200000, 4, 1, 0, 0, 32'h0);
        do_op(32'h3F800000, 32'h40000000, 3, 0, 0, 0, 32'h40400000);
        do_op(32'h40A00000, 32'hC0000000, 5, 0, 0, 0, 32'h40400000);
        do_reset();
        check("err_cleared", 32'(TimeoutErr), 32'd0);
        do_op(32'h3F800000, 32'h40000000, 4, 0, 0, 5, 32'h40400000);
        do_op(32'hFF800000, 32'h3F800000, 4, 0, 0, 5, 32'h0);

        // Reset while waiting on a silent adder: the aborted op must never surface.
        @(negedge Clock);
        adder_silent = 1'b1;
        hold_stale   = 1'b0;
        InValid = 1'b1; InOp1 = 32'h3F800000; InOp2 = 32'h40000000;
        @(posedge Clock);
        @(negedge Clock);
        InValid = 1'b0;
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        check("abort_in_ready", 32'(InReady), 32'd1);
        check("abort_out_valid", 32'(OutValid), 32'd0);
        Reset = 1'b0;
        quiet = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if (OutValid) quiet++;
        end
        check("abort_no_result", 32'(quiet), 32'd0);
        check("abort_no_err", 32'(TimeoutErr), 32'd0);

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            do_op(rand_operand(), rand_operand(), $urandom_range(1, TO - 1),
                  ($urandom_range(0, 9) == 0), 1'b0, $urandom_range(0, 3), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
